// File: rtl/video_pkg.sv
// Shared video definitions: RGB444 pixel layout, default frame geometry and
// the window controller state encoding.
package video_pkg;
  localparam int PIX_W     = 12;
  localparam int CH_W      = 4;
  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } ctrl_state_t;
endpackage

// File: rtl/gaussian_3x3.sv
// Combinational 3x3 Gaussian blur, kernel [1 2 1;2 4 2;1 2 1]/16 per channel.
// Window is row-major: tap (r,c) sits at bits [(r*3+c)*PIX_W +: PIX_W].
module gaussian_3x3 #(
  parameter int PIX_W = video_pkg::PIX_W
) (
  input  logic [9*PIX_W-1:0] win,
  output logic [PIX_W-1:0]   blur
);
  import video_pkg::*;

  localparam int NCH   = PIX_W / CH_W;
  localparam int SUM_W = CH_W + 4;

  function automatic int tap_shift(input int idx);
    return (idx == 1) ? 1 : 0;
  endfunction

  // Divide by 16 by keeping the top channel-width bits; the sum never exceeds 16*max.
  function automatic logic [CH_W-1:0] trunc_div16(input logic [SUM_W-1:0] s);
    return s[SUM_W-1 -: CH_W];
  endfunction

  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [CH_W-1:0]  tap;
    blur = '0;
    sum  = '0;
    tap  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      sum = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap = win[(r*3+c)*PIX_W + ch*CH_W +: CH_W];
          sum = sum + (SUM_W'(tap) << (tap_shift(r) + tap_shift(c)));
        end
      end
      blur[ch*CH_W +: CH_W] = trunc_div16(sum);
    end
  end
endmodule

// File: rtl/line_buffer.sv
// One video line of storage: simple dual-port RAM with a registered read port.
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/gaussian_window_ctrl.sv
// Streaming 3x3 window controller: two line buffers plus a shift-register
// window feed the Gaussian block; border pixels pass through unmodified.
module gaussian_window_ctrl #(
  parameter int IMG_W = video_pkg::IMG_W_DEF,
  parameter int IMG_H = video_pkg::IMG_H_DEF,
  parameter int PIX_W = video_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             frame_done
);
  import video_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  ctrl_state_t state, state_nxt;

  logic [XW-1:0]    x, ox, col, col_nxt, rd_addr;
  logic [YW-1:0]    y, oy;
  logic             flush_end;
  logic             can_out, acc, take_sof, shift_in, prod_in, prod_fl, produce, last_xfer;
  logic             border;
  logic [PIX_W-1:0] lb0_q, lb1_q, centre, blur, res;
  logic [PIX_W-1:0] new_col [3];
  logic [PIX_W-1:0] win_p0 [3][2];
  logic [9*PIX_W-1:0] win_flat;

  always_comb begin
    can_out = out_ready || !out_valid;
    case (state)
      IDLE, FILL: in_ready = 1'b1;
      RUN:        in_ready = can_out;
      default:    in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;

    acc       = in_valid && in_ready;
    take_sof  = acc && in_sof;
    shift_in  = acc && (in_sof || state != IDLE);
    prod_in   = acc && !in_sof &&
                ((state == RUN) || (state == FILL && x == XW'(1) && y == YW'(1)));
    prod_fl   = (state == FLUSH) && can_out && !flush_end;
    produce   = prod_in || prod_fl;
    last_xfer = (state == FLUSH) && flush_end && out_valid && out_ready;

    // Read one column ahead so the RAM output is ready for the next shift.
    col     = take_sof ? '0 : x;
    col_nxt = (col == X_LAST) ? '0 : col + 1'b1;
    rd_addr = (shift_in || prod_fl) ? col_nxt : x;

    state_nxt = state;
    case (state)
      IDLE:  if (take_sof) state_nxt = FILL;
      FILL:  if (take_sof) state_nxt = FILL;
             else if (prod_in) state_nxt = RUN;
      RUN:   if (take_sof) state_nxt = FILL;
             else if (acc && x == X_LAST && y == Y_LAST) state_nxt = FLUSH;
      FLUSH: if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (shift_in),
    .waddr (col),
    .wdata (in_pixel),
    .raddr (rd_addr),
    .rdata (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (shift_in),
    .waddr (col),
    .wdata (lb0_q),
    .raddr (rd_addr),
    .rdata (lb1_q)
  );

  // Stage p0: the incoming column completes the window combinationally, so
  // only the two older columns need registers.
  always_comb begin
    new_col[0] = lb1_q;
    new_col[1] = lb0_q;
    new_col[2] = prod_fl ? '0 : in_pixel;
    win_flat   = '0;
    for (int r = 0; r < 3; r++) begin
      win_flat[(r*3+0)*PIX_W +: PIX_W] = win_p0[r][0];
      win_flat[(r*3+1)*PIX_W +: PIX_W] = win_p0[r][1];
      win_flat[(r*3+2)*PIX_W +: PIX_W] = new_col[r];
    end
    centre = win_p0[1][1];
    border = (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
    res    = border ? centre : blur;
  end

  always_ff @(posedge clk) begin
    if (shift_in || prod_fl) begin
      for (int r = 0; r < 3; r++) begin
        win_p0[r][0] <= win_p0[r][1];
        win_p0[r][1] <= new_col[r];
      end
    end
  end

  gaussian_3x3 #(.PIX_W(PIX_W)) u_blur (
    .win  (win_flat),
    .blur (blur)
  );

  // Stage p1: position counters and the single-entry output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      ox         <= '0;
      oy         <= '0;
      flush_end  <= 1'b0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_xfer;

      if (shift_in || prod_fl) x <= col_nxt;
      if (take_sof) y <= '0;
      else if (shift_in && col == X_LAST) y <= (y == Y_LAST) ? '0 : y + 1'b1;

      if (take_sof || last_xfer) begin
        ox        <= '0;
        oy        <= '0;
        flush_end <= 1'b0;
      end else if (produce) begin
        ox <= (ox == X_LAST) ? '0 : ox + 1'b1;
        if (ox == X_LAST) oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
        if (ox == X_LAST && oy == Y_LAST) flush_end <= 1'b1;
      end

      if (take_sof) begin
        out_valid <= 1'b0;
      end else if (produce) begin
        out_valid <= 1'b1;
        out_pixel <= res;
        out_sof   <= (ox == '0) && (oy == '0);
        out_eol   <= (ox == X_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Self-checking bench for gaussian_window_ctrl on an 8x6 frame: scoreboard of
// expected outputs from a frame-level reference model plus table-driven cases.
module tb_gaussian_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid, out_ready, out_sof, out_eol, frame_done;
  logic [PW-1:0] out_pixel;

  always #5 clk = ~clk;

  gaussian_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [PW-1:0] pix;
    logic          sof;
    logic          eol;
  } exp_t;

  typedef struct {
    int pat;
    int rdy;
    int gap;
  } fcase_t;

  typedef struct {
    int            x;
    int            y;
    logic [PW-1:0] exp;
  } ipt_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;
  int            out_cnt = 0;
  int            frames = 0;
  int            rdy_pct = 100;
  int            gap_pct = 0;
  logic [PW-1:0] img [N];
  logic [PW-1:0] cap [N];
  logic          hold_vld = 1'b0;
  logic [PW-1:0] hold_pix;
  fcase_t        cases [6];
  ipt_t          ipts [10];
  int            saved_out, saved_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input int x, input int y);
    int acc, wt, res;
    if (x == 0 || x == W-1 || y == 0 || y == H-1) return img[y*W+x];
    res = 0;
    for (int ch = 0; ch < 3; ch++) begin
      acc = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          wt  = (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
          acc = acc + wt * ((int'(img[(y+dy)*W + x+dx]) >> (4*ch)) & 15);
        end
      res = res | (((acc / 16) & 15) << (4*ch));
    end
    return PW'(res);
  endfunction

  task automatic push_exp(input int first, input int count);
    exp_t e;
    for (int i = first; i < first + count; i++) begin
      e.pix = model(i % W, i / W);
      e.sof = (i == 0);
      e.eol = ((i % W) == W-1);
      sb.push_back(e);
    end
  endtask

  task automatic fill_img(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       img[i] = 12'hABC;
        1:       img[i] = (i == 3*W+3) ? 12'hFFF : 12'h000;
        2:       img[i] = PW'(i);
        default: img[i] = PW'($urandom);
      endcase
    end
  endtask

  task automatic send_pixel(input logic [PW-1:0] p, input logic s);
    int g, n;
    g = (gap_pct > 0 && $urandom_range(99) < gap_pct) ? $urandom_range(3, 1) : 0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = s;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 1000) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int count);
    for (int i = 0; i < count; i++) send_pixel(img[i], i == 0);
  endtask

  task automatic wait_done(input int expected);
    int n;
    n = 0;
    while (done_cnt < expected && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("frame_done_count", done_cnt, expected);
    chk("queue_drained", sb.size(), 0);
  endtask

  // Output monitor: scoreboard compare, capture, and stall-stability check.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_vld = 1'b0;
    end else begin
      if (frame_done) done_cnt++;
      if (hold_vld) chk("hold_stable", {out_valid, out_pixel}, {1'b1, hold_pix});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {out_sof, out_eol, out_pixel}, 0);
        end else begin
          e = sb.pop_front();
          chk("out_pixel", out_pixel, e.pix);
          chk("out_sof", out_sof, e.sof);
          chk("out_eol", out_eol, e.eol);
        end
        if (out_cnt < N) cap[out_cnt] = out_pixel;
        out_cnt++;
      end
      hold_vld = out_valid && !out_ready;
      hold_pix = out_pixel;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cases[0] = '{0, 100, 0};
    cases[1] = '{1, 100, 0};
    cases[2] = '{1, 50, 50};
    cases[3] = '{2, 100, 0};
    cases[4] = '{2, 60, 40};
    cases[5] = '{3, 50, 30};

    ipts[0] = '{3, 3, 12'h333};
    ipts[1] = '{2, 3, 12'h111};
    ipts[2] = '{4, 3, 12'h111};
    ipts[3] = '{3, 2, 12'h111};
    ipts[4] = '{3, 4, 12'h111};
    ipts[5] = '{2, 2, 12'h000};
    ipts[6] = '{4, 4, 12'h000};
    ipts[7] = '{2, 4, 12'h000};
    ipts[8] = '{4, 2, 12'h000};
    ipts[9] = '{1, 1, 12'h000};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pixel", out_pixel, 0);
    chk("reset_out_sof", out_sof, 0);
    chk("reset_out_eol", out_eol, 0);
    chk("reset_frame_done", frame_done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    for (int c = 0; c < 6; c++) begin
      rdy_pct = cases[c].rdy;
      gap_pct = cases[c].gap;
      fill_img(cases[c].pat);
      out_cnt = 0;
      push_exp(0, N);
      send_frame(N);
      frames++;
      wait_done(frames);
      chk("frame_out_count", out_cnt, N);
      if (cases[c].pat == 1)
        for (int k = 0; k < 10; k++)
          chk("impulse_point", cap[ipts[k].y*W + ipts[k].x], ipts[k].exp);
    end

    // Abort: new in_sof at input index 20; only 11 outputs of the old frame escape.
    rdy_pct = 100;
    gap_pct = 0;
    fill_img(2);
    push_exp(0, 11);
    for (int i = 0; i < 20; i++) send_pixel(img[i], i == 0);
    fill_img(3);
    push_exp(0, N);
    send_frame(N);
    frames++;
    wait_done(frames);

    // Reset while flushing the tail of a frame.
    fill_img(2);
    push_exp(0, N);
    send_frame(N);
    reset = 1'b1;
    #1;
    chk("flush_rst_in_ready", in_ready, 0);
    chk("flush_rst_out_valid", out_valid, 0);
    chk("flush_rst_out_pixel", out_pixel, 0);
    chk("flush_rst_out_sof", out_sof, 0);
    chk("flush_rst_out_eol", out_eol, 0);
    chk("flush_rst_frame_done", frame_done, 0);
    chk("flush_pending", sb.size(), 10);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    saved_out  = out_cnt;
    saved_done = done_cnt;
    for (int i = 0; i < 5; i++) send_pixel(PW'(12'h5A0 + i), 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_discard_outputs", out_cnt, saved_out);
    chk("idle_discard_done", done_cnt, saved_done);

    rdy_pct = 70;
    gap_pct = 20;
    fill_img(3);
    push_exp(0, N);
    send_frame(N);
    frames++;
    wait_done(frames);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
